// File: rtl/niosii_timer_irq_servicer.sv
// Avalon-MM master servicing the Nios II interval timer: enables its irq, reads/clears TO, counts ticks.
// Optional no-timeout watchdog compiled in when TIMER_SVC_WDOG_EN is defined.
module niosii_timer_irq_servicer #(
    parameter int CNT_W      = 32,
    parameter int SETTLE_CYC = 2,
    parameter int WDOG_CYC   = 200000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [2:0]       avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [15:0]      avm_writedata,
    input  logic [15:0]      avm_readdata,
    input  logic             avm_waitrequest,
    input  logic             irq,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic [CNT_W-1:0] spurious_count,
    output logic             wdog_err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CFG_WR   = 3'd1,
        S_WAIT_IRQ = 3'd2,
        S_RD_REQ   = 3'd3,
        S_RD_DATA  = 3'd4,
        S_CLR_WR   = 3'd5,
        S_SETTLE   = 3'd6,
        S_DIS_WR   = 3'd7
    } state_e;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    state_e            state_q, state_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]  tick_count_q, tick_count_d;
    logic [CNT_W-1:0]  spur_count_q, spur_count_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [2:0]        addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              tick_s;
    logic              unused_rd_s;

    // Only the TO bit of the status word matters here.
    assign unused_rd_s = ^avm_readdata[15:1];
    assign tick_s      = (state_q == S_RD_DATA) && avm_readdata[0];

    // State, counters and bus outputs; strobes clear asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= '0;
            tick_count_q <= '0;
            spur_count_q <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 3'd0;
            wdata_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            tick_count_q <= tick_count_d;
            spur_count_q <= spur_count_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = '0;
        tick_count_d = tick_count_q;
        spur_count_d = spur_count_q;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_CFG_WR;
                else    state_d = S_IDLE;
            end
            S_CFG_WR: begin
                if (!avm_waitrequest) state_d = S_SETTLE;
                else                  state_d = S_CFG_WR;
            end
            S_WAIT_IRQ: begin
                // Disable wins over a coincident interrupt.
                if (!en)      state_d = S_DIS_WR;
                else if (irq) state_d = S_RD_REQ;
                else          state_d = S_WAIT_IRQ;
            end
            S_RD_REQ: begin
                if (!avm_waitrequest) state_d = S_RD_DATA;
                else                  state_d = S_RD_REQ;
            end
            S_RD_DATA: begin
                if (avm_readdata[0]) begin
                    tick_count_d = tick_count_q + CNT_W'(1);
                    state_d      = S_CLR_WR;
                end else begin
                    spur_count_d = spur_count_q + CNT_W'(1);
                    state_d      = S_SETTLE;
                end
            end
            S_CLR_WR: begin
                if (!avm_waitrequest) state_d = S_SETTLE;
                else                  state_d = S_CLR_WR;
            end
            S_SETTLE: begin
                // Gives the registered timer irq time to fall after the clear.
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_WAIT_IRQ;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                    state_d      = S_SETTLE;
                end
            end
            S_DIS_WR: begin
                if (!avm_waitrequest) state_d = S_IDLE;
                else                  state_d = S_DIS_WR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus request decode from the upcoming state so outputs leave a register.
    always_comb begin
        read_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = 3'd0;
        wdata_d = 16'h0000;
        case (state_d)
            S_CFG_WR: begin
                write_d = 1'b1;
                addr_d  = 3'd1;
                wdata_d = 16'h0001;
            end
            S_RD_REQ: read_d  = 1'b1;
            S_CLR_WR: write_d = 1'b1;
            S_DIS_WR: begin
                write_d = 1'b1;
                addr_d  = 3'd1;
            end
            default: read_d = 1'b0;
        endcase
    end

    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign tick           = tick_s;
    assign tick_count     = tick_count_q;
    assign spurious_count = spur_count_q;

`ifdef TIMER_SVC_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

    logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic            wdog_err_q, wdog_err_d;

    // Watchdog registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    // Count enabled cycles since the last tick; counting stops once the error latches.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        wdog_err_d = wdog_err_q;
        if (tick_s || (state_q == S_CFG_WR)) begin
            wdog_cnt_d = '0;
        end else if (en && !wdog_err_q) begin
            wdog_cnt_d = wdog_cnt_q + WD_W'(1);
            if (wdog_cnt_q == WD_LAST) wdog_err_d = 1'b1;
            else                       wdog_err_d = 1'b0;
        end else begin
            wdog_cnt_d = wdog_cnt_q;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    localparam int unused_wdog_cyc = WDOG_CYC;
    assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_niosii_timer_irq_servicer.sv
// Self-checking bench for niosii_timer_irq_servicer: Avalon slave model with random stalls and a
// transaction-level reference of the expected service sequence and counters.
`timescale 1ns/1ps
module tb_niosii_timer_irq_servicer;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             en = 1'b0;
    logic             irq = 1'b0;
    logic [2:0]       avm_address;
    logic             avm_read;
    logic             avm_write;
    logic [15:0]      avm_writedata;
    logic [15:0]      avm_readdata = 16'h0000;
    logic             avm_waitrequest = 1'b0;
    logic             tick;
    logic [CNT_W-1:0] tick_count;
    logic [CNT_W-1:0] spurious_count;
    logic             wdog_err;

    typedef struct packed {logic w; logic [2:0] a; logic [15:0] d;} txn_t;
    localparam txn_t T_RD  = {1'b0, 3'd0, 16'h0000};
    localparam txn_t T_CLR = {1'b1, 3'd0, 16'h0000};
    localparam txn_t T_CFG = {1'b1, 3'd1, 16'h0001};
    localparam txn_t T_DIS = {1'b1, 3'd1, 16'h0000};

    int          total = 0;
    int          bad = 0;
    txn_t        txq[$];
    int          wr_mode = 0;
    int          stall_cnt = 0;
    int          rd_acc = 0;
    int          tick_seen = 0;
    logic        rd_pend = 1'b0;
    logic [15:0] rdval = 16'h0000;
    logic        prev_stall = 1'b0;
    logic        prev_tick = 1'b0;
    logic [20:0] prev_bus = '0;
    logic        m_strobe, m_wr, m_acc;
    int          exp_tick = 0;
    int          exp_spur = 0;

    niosii_timer_irq_servicer #(.CNT_W(CNT_W), .SETTLE_CYC(2), .WDOG_CYC(100)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .irq(irq), .tick(tick),
        .tick_count(tick_count), .spurious_count(spurious_count), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    // Slave model: picks waitrequest for the next edge, logs accepted transfers, checks bus rules.
    always @(negedge clk) begin
        m_strobe = avm_read | avm_write;
        if (wr_mode == 1)      m_wr = ($urandom_range(0, 1) == 1);
        else if (wr_mode == 2) m_wr = m_strobe && (stall_cnt < 5);
        else                   m_wr = 1'b0;
        m_acc = m_strobe && !m_wr;
        if (reset_n) begin
            total++;
            if (avm_read && avm_write) begin
                bad++;
                $display("FAIL rw_exclusive got read=%b write=%b want not both", avm_read, avm_write);
            end
            if (prev_stall) begin
                total++;
                if ({avm_read, avm_write, avm_address, avm_writedata} !== prev_bus) begin
                    bad++;
                    $display("FAIL bus_stable got=%h want=%h",
                             {avm_read, avm_write, avm_address, avm_writedata}, prev_bus);
                end
            end
            if (tick) begin
                tick_seen++;
                total++;
                if (prev_tick) begin
                    bad++;
                    $display("FAIL tick_pulse got=2 consecutive want=1 cycle");
                end
            end
            if (m_acc) begin
                txq.push_back({avm_write, avm_address, avm_write ? avm_writedata : 16'h0000});
                if (avm_read) rd_acc++;
            end
        end
        prev_stall = reset_n && m_strobe && m_wr;
        prev_bus   = {avm_read, avm_write, avm_address, avm_writedata};
        prev_tick  = reset_n && tick;
        rd_pend    = reset_n && m_acc && avm_read;
        stall_cnt  = (m_strobe && !m_acc) ? stall_cnt + 1 : 0;
        avm_waitrequest = m_wr;
    end

    // Read data is valid only in the cycle after acceptance; otherwise the inverse is shown.
    always @(posedge clk) begin
        #1;
        avm_readdata = rd_pend ? rdval : ~rdval;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=hang want=finish");
        $fatal(1, "bench timeout");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One interrupt service: raise irq until the status read is taken, then let it finish.
    task automatic service(input logic [15:0] rd, input int exp_n);
        int acc0;
        txq.delete();
        tick_seen = 0;
        acc0  = rd_acc;
        rdval = rd;
        irq   = 1'b1;
        for (int c = 0; c < 200 && rd_acc == acc0; c++) cyc(1);
        irq = 1'b0;
        for (int c = 0; c < 200 && txq.size() < exp_n; c++) cyc(1);
        cyc(6);
    endtask

    task automatic test_reset();
        int n;
        en = 1'b1;
        reset_n = 1'b0;
        cyc(3);
        total++;
        if ({avm_read, avm_write, avm_address, avm_writedata, tick, tick_count, spurious_count, wdog_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {avm_read, avm_write, avm_address, avm_writedata, tick, tick_count, spurious_count, wdog_err});
        end
        txq.delete();
        reset_n = 1'b1;
        n = 0;
        while (!avm_write && n < 10) begin
            cyc(1);
            n++;
        end
        total++;
        if (n > 2 || n == 0) begin
            bad++;
            $display("FAIL cfg_latency got=%0d want<=2", n);
        end
        total++;
        if ({avm_address, avm_writedata} !== {3'd1, 16'h0001}) begin
            bad++;
            $display("FAIL cfg_write got=%h want=%h", {avm_address, avm_writedata}, {3'd1, 16'h0001});
        end
        cyc(4);
        total++;
        if (txq.size() != 1 || txq[0] !== T_CFG) begin
            bad++;
            $display("FAIL cfg_txn got=%0d/%h want=1/%h", txq.size(), txq[0], T_CFG);
        end
    endtask

    task automatic test_wdog();
        txq.delete();
        cyc(80);
        total++;
        if (wdog_err !== 1'b0) begin
            bad++;
            $display("FAIL wdog_early got=%b want=0", wdog_err);
        end
        cyc(40);
        total++;
`ifdef TIMER_SVC_WDOG_EN
        if (wdog_err !== 1'b1) begin
            bad++;
            $display("FAIL wdog_late got=%b want=1", wdog_err);
        end
`else
        if (wdog_err !== 1'b0) begin
            bad++;
            $display("FAIL wdog_late got=%b want=0", wdog_err);
        end
`endif
        total++;
        if (txq.size() != 0) begin
            bad++;
            $display("FAIL idle_bus got=%0d want=0 transfers", txq.size());
        end
    endtask

    task automatic test_latency();
        int n;
        wr_mode = 0;
        rdval = 16'h0001;
        irq = 1'b1;
        n = 0;
        while (!avm_write && n < 20) begin
            cyc(1);
            n++;
        end
        irq = 1'b0;
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL service_latency got=%0d want=3", n);
        end
        total++;
        if ({avm_address, avm_writedata} !== {3'd0, 16'h0000}) begin
            bad++;
            $display("FAIL clear_write got=%h want=0", {avm_address, avm_writedata});
        end
        cyc(6);
        exp_tick = (exp_tick + 1) % 16;
        total++;
        if (tick_count !== 4'(exp_tick)) begin
            bad++;
            $display("FAIL latency_count got=%0d want=%0d", tick_count, exp_tick);
        end
    endtask

    task automatic test_tick();
        service(16'h0003, 2);
        exp_tick = (exp_tick + 1) % 16;
        total++;
        if (txq.size() != 2 || txq[0] !== T_RD || txq[1] !== T_CLR) begin
            bad++;
            $display("FAIL tick_txns got=%0d/%h/%h want=2/%h/%h", txq.size(), txq[0], txq[1], T_RD, T_CLR);
        end
        total++;
        if (tick_seen != 1) begin
            bad++;
            $display("FAIL tick_pulses got=%0d want=1", tick_seen);
        end
        total++;
        if (tick_count !== 4'(exp_tick) || spurious_count !== 4'(exp_spur)) begin
            bad++;
            $display("FAIL tick_counts got=%0d/%0d want=%0d/%0d", tick_count, spurious_count, exp_tick, exp_spur);
        end
    endtask

    task automatic test_spurious();
        service(16'h0002, 1);
        exp_spur = (exp_spur + 1) % 16;
        total++;
        if (txq.size() != 1 || txq[0] !== T_RD) begin
            bad++;
            $display("FAIL spur_txns got=%0d/%h want=1/%h", txq.size(), txq[0], T_RD);
        end
        total++;
        if (tick_seen != 0) begin
            bad++;
            $display("FAIL spur_pulses got=%0d want=0", tick_seen);
        end
        total++;
        if (tick_count !== 4'(exp_tick) || spurious_count !== 4'(exp_spur)) begin
            bad++;
            $display("FAIL spur_counts got=%0d/%0d want=%0d/%0d", tick_count, spurious_count, exp_tick, exp_spur);
        end
    endtask

    // Mode 1 = random stalls, mode 2 = five-cycle stall on every access.
    task automatic test_services(input int mode, input int count, input int forced);
        wr_mode = mode;
        for (int i = 0; i < count; i++) begin
            logic [15:0] rd;
            int to;
            rd = 16'($urandom);
            if (i < forced)          rd[0] = 1'b1;
            else if (i < 2 * forced) rd[0] = 1'b0;
            to = int'(rd[0]);
            service(rd, (to == 1) ? 2 : 1);
            exp_tick = (exp_tick + to) % 16;
            exp_spur = (exp_spur + 1 - to) % 16;
            total++;
            if (txq.size() != 1 + to || txq[0] !== T_RD || (to == 1 && txq[1] !== T_CLR)) begin
                bad++;
                $display("FAIL svc_txns[%0d] got=%0d/%h want=%0d/%h", i, txq.size(), txq[0], 1 + to, T_RD);
            end
            total++;
            if (tick_seen != to) begin
                bad++;
                $display("FAIL svc_pulses[%0d] got=%0d want=%0d", i, tick_seen, to);
            end
            total++;
            if (tick_count !== 4'(exp_tick) || spurious_count !== 4'(exp_spur)) begin
                bad++;
                $display("FAIL svc_counts[%0d] got=%0d/%0d want=%0d/%0d", i, tick_count, spurious_count, exp_tick, exp_spur);
            end
        end
        wr_mode = 0;
    endtask

    task automatic test_disable();
        int acc0;
        wr_mode = 0;
        txq.delete();
        acc0 = rd_acc;
        en  = 1'b0;
        irq = 1'b1;
        for (int c = 0; c < 50 && txq.size() < 1; c++) cyc(1);
        cyc(4);
        irq = 1'b0;
        cyc(5);
        total++;
        if (txq.size() != 1 || txq[0] !== T_DIS || rd_acc != acc0) begin
            bad++;
            $display("FAIL disable_txns got=%0d/%h reads=%0d want=1/%h reads=0", txq.size(), txq[0], rd_acc - acc0, T_DIS);
        end
        total++;
        if (tick_count !== 4'(exp_tick) || spurious_count !== 4'(exp_spur)) begin
            bad++;
            $display("FAIL disable_counts got=%0d/%0d want=%0d/%0d", tick_count, spurious_count, exp_tick, exp_spur);
        end
        txq.delete();
        en = 1'b1;
        for (int c = 0; c < 50 && txq.size() < 1; c++) cyc(1);
        cyc(4);
        total++;
        if (txq.size() != 1 || txq[0] !== T_CFG) begin
            bad++;
            $display("FAIL reenable_txns got=%0d/%h want=1/%h", txq.size(), txq[0], T_CFG);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wr_mode = 2;
        rdval = 16'h0001;
        irq = 1'b1;
        for (int c = 0; c < 50 && !avm_read; c++) cyc(1);
        cyc(2);
        reset_n = 1'b0;
        #1;
        total++;
        if ({avm_read, avm_write} !== 2'b00) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=00", {avm_read, avm_write});
        end
        irq = 1'b0;
        wr_mode = 0;
        cyc(3);
        exp_tick = 0;
        exp_spur = 0;
        total++;
        if (tick_count !== 4'd0 || spurious_count !== 4'd0 || wdog_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_counts got=%0d/%0d/%b want=0/0/0", tick_count, spurious_count, wdog_err);
        end
        reset_n = 1'b1;
        n = 0;
        while (!avm_write && n < 10) begin
            cyc(1);
            n++;
        end
        total++;
        if (n > 2 || n == 0 || {avm_address, avm_writedata} !== {3'd1, 16'h0001}) begin
            bad++;
            $display("FAIL restart_cfg got=%0d/%h want<=2/%h", n, {avm_address, avm_writedata}, {3'd1, 16'h0001});
        end
        cyc(4);
        service(16'h0001, 2);
        exp_tick = 1;
        total++;
        if (tick_count !== 4'(exp_tick) || txq.size() != 2) begin
            bad++;
            $display("FAIL restart_service got=%0d/%0d want=%0d/2", tick_count, txq.size(), exp_tick);
        end
    endtask

    initial begin
        test_reset();
        test_wdog();
        test_latency();
        test_tick();
        test_spurious();
        test_services(2, 4, 1);
        test_services(1, 40, 18);
        test_disable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
